// File: rtl/cam_cmd_ctrl.sv
// cam_cmd_ctrl
// Command sequencer for the associative-processor CAM cell array. It takes one
// command at a time and drives the array inputs for that command. It then
// returns read data, search tags or a plain acknowledge on the response port.
// A tag-conditional column write is done as a read-modify-write over two
// cycles: EXEC reads the old column and RMW_WR writes the merged column.
//
// Ports
//   clk, rstIn            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; the design accepts only in IDLE
//   cmd_op, cmd_addr      operation code and row/column address
//   cmd_data_row/col      write data for row ops and column ops
//   cmd_key, cmd_mask     search key bit and column mask
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_err     read data, tags or 0, and the error flag
//   tag_reg               tags from the last SEARCH
//   arr_*  (out)          array mode, addresses, data, key/mask, write inhibit
//   arr_*  (in)           array read data and tag lines (combinational)
module cam_cmd_ctrl #(
    parameter int         DATA_WIDTH     = 8,
    parameter int         DATA_DEPTH     = 16,
    parameter int         ADDR_WIDTH_CAM = 8,
    parameter logic [2:0] RowxRow        = 3'd1,
    parameter logic [2:0] ColxCol        = 3'd2,
    parameter logic [2:0] COPY_B         = 3'd3
) (
    input  logic                      clk,
    input  logic                      rstIn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [ADDR_WIDTH_CAM-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data_row,
    input  logic [DATA_DEPTH-1:0]     cmd_data_col,
    input  logic                      cmd_key,
    input  logic [DATA_WIDTH-1:0]     cmd_mask,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_DEPTH-1:0]     rsp_data,
    output logic                      rsp_err,
    output logic [DATA_DEPTH-1:0]     tag_reg,
    output logic [2:0]                arr_input_mode,
    output logic                      arr_wr_inhibit,
    output logic [ADDR_WIDTH_CAM-1:0] arr_addr_in_row,
    output logic [ADDR_WIDTH_CAM-1:0] arr_addr_in_col,
    output logic [ADDR_WIDTH_CAM-1:0] arr_addr_out_row,
    output logic [ADDR_WIDTH_CAM-1:0] arr_addr_out_col,
    output logic [DATA_WIDTH-1:0]     arr_ip_row,
    output logic [DATA_DEPTH-1:0]     arr_ip_col,
    output logic                      arr_key,
    output logic [DATA_WIDTH-1:0]     arr_mask,
    input  logic [DATA_WIDTH-1:0]     arr_q_out_row,
    input  logic [DATA_DEPTH-1:0]     arr_q_out_col,
    input  logic [DATA_DEPTH-1:0]     arr_tag_row
);

    localparam logic [2:0] OP_ROW_WR     = 3'd0;
    localparam logic [2:0] OP_COL_WR     = 3'd1;
    localparam logic [2:0] OP_ROW_RD     = 3'd2;
    localparam logic [2:0] OP_COL_RD     = 3'd3;
    localparam logic [2:0] OP_SEARCH     = 3'd4;
    localparam logic [2:0] OP_TAG_COL_WR = 3'd5;
    localparam logic [2:0] OP_COPY_B     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL    = 3'd7;

    // The limits are one bit wider than the address so DATA_DEPTH itself fits.
    localparam logic [ADDR_WIDTH_CAM:0] ROW_LIMIT = (ADDR_WIDTH_CAM+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH_CAM:0] COL_LIMIT = (ADDR_WIDTH_CAM+1)'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, RMW_WR, RESP} state_t;

    state_t                    state;
    logic [2:0]                op_q;
    logic [ADDR_WIDTH_CAM-1:0] addr_q;
    logic [DATA_DEPTH-1:0]     data_col_q;
    logic                      err_q;

    logic is_row_op;
    logic is_col_op;
    logic cmd_bad;

    always_comb begin
        is_row_op = (cmd_op == OP_ROW_WR) || (cmd_op == OP_ROW_RD);
        is_col_op = (cmd_op == OP_COL_WR) || (cmd_op == OP_COL_RD) ||
                    (cmd_op == OP_TAG_COL_WR);
        cmd_bad   = (cmd_op == OP_ILLEGAL) ||
                    (is_row_op && ({1'b0, cmd_addr} >= ROW_LIMIT)) ||
                    (is_col_op && ({1'b0, cmd_addr} >= COL_LIMIT));
    end

    // The array inputs are registered. The values for EXEC are loaded on the
    // accept edge, so the array sees them for the whole EXEC cycle and a
    // write commits on the edge that ends EXEC.
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            state            <= IDLE;
            op_q             <= '0;
            addr_q           <= '0;
            data_col_q       <= '0;
            err_q            <= 1'b0;
            cmd_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            rsp_err          <= 1'b0;
            tag_reg          <= '0;
            arr_input_mode   <= 3'd0;
            arr_wr_inhibit   <= 1'b1;
            arr_addr_in_row  <= '0;
            arr_addr_in_col  <= '0;
            arr_addr_out_row <= '0;
            arr_addr_out_col <= '0;
            arr_ip_row       <= '0;
            arr_ip_col       <= '0;
            arr_key          <= 1'b0;
            arr_mask         <= '0;
        end else begin
            // The array rests in this state unless a case below overrides it.
            arr_input_mode   <= 3'd0;
            arr_wr_inhibit   <= 1'b1;
            arr_addr_in_row  <= '0;
            arr_addr_in_col  <= '0;
            arr_addr_out_row <= '0;
            arr_addr_out_col <= '0;
            arr_ip_row       <= '0;
            arr_ip_col       <= '0;
            arr_key          <= 1'b0;
            arr_mask         <= '0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        addr_q     <= cmd_addr;
                        data_col_q <= cmd_data_col;
                        err_q      <= cmd_bad;
                        cmd_ready  <= 1'b0;
                        state      <= EXEC;
                        // A bad command passes through EXEC with the array at rest.
                        if (!cmd_bad) begin
                            case (cmd_op)
                                OP_ROW_WR: begin
                                    arr_input_mode  <= RowxRow;
                                    arr_addr_in_row <= cmd_addr;
                                    arr_ip_row      <= cmd_data_row;
                                    arr_wr_inhibit  <= 1'b0;
                                end
                                OP_COL_WR: begin
                                    arr_input_mode  <= ColxCol;
                                    arr_addr_in_col <= cmd_addr;
                                    arr_ip_col      <= cmd_data_col;
                                    arr_wr_inhibit  <= 1'b0;
                                end
                                OP_ROW_RD: begin
                                    arr_input_mode   <= RowxRow;
                                    arr_addr_out_row <= cmd_addr;
                                end
                                OP_COL_RD, OP_TAG_COL_WR: begin
                                    arr_input_mode   <= ColxCol;
                                    arr_addr_out_col <= cmd_addr;
                                end
                                OP_SEARCH: begin
                                    arr_key  <= cmd_key;
                                    arr_mask <= cmd_mask;
                                end
                                OP_COPY_B: begin
                                    arr_input_mode <= COPY_B;
                                    arr_wr_inhibit <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                EXEC: begin
                    rsp_err   <= err_q;
                    rsp_data  <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                    if (!err_q) begin
                        case (op_q)
                            OP_ROW_RD: rsp_data <= DATA_DEPTH'(arr_q_out_row);
                            OP_COL_RD: rsp_data <= arr_q_out_col;
                            OP_SEARCH: begin
                                rsp_data <= arr_tag_row;
                                tag_reg  <= arr_tag_row;
                            end
                            OP_TAG_COL_WR: begin
                                // Merge on the old column: tagged rows take new data.
                                // Untagged rows are written back with the value they hold.
                                rsp_valid       <= 1'b0;
                                state           <= RMW_WR;
                                arr_input_mode  <= ColxCol;
                                arr_addr_in_col <= addr_q;
                                arr_ip_col      <= (tag_reg & data_col_q) |
                                                   (~tag_reg & arr_q_out_col);
                                arr_wr_inhibit  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                RMW_WR: begin
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Testbench for cam_cmd_ctrl. A behavioural CAM array model answers the
// controller. A separate command-level reference (a shadow memory and
// tags) predicts each response, its latency and the array contents.
module tb_cam_cmd_ctrl;
    localparam int DW = 8;
    localparam int DD = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstIn;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data_row;
    logic [DD-1:0] cmd_data_col;
    logic          cmd_key;
    logic [DW-1:0] cmd_mask;
    logic          rsp_valid, rsp_ready;
    logic [DD-1:0] rsp_data;
    logic          rsp_err;
    logic [DD-1:0] tag_reg;
    logic [2:0]    arr_input_mode;
    logic          arr_wr_inhibit;
    logic [AW-1:0] arr_addr_in_row, arr_addr_in_col, arr_addr_out_row, arr_addr_out_col;
    logic [DW-1:0] arr_ip_row;
    logic [DD-1:0] arr_ip_col;
    logic          arr_key;
    logic [DW-1:0] arr_mask;
    logic [DW-1:0] arr_q_out_row;
    logic [DD-1:0] arr_q_out_col;
    logic [DD-1:0] arr_tag_row;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cam_cmd_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH_CAM(AW)) dut (
        .clk(clk), .rstIn(rstIn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data_row(cmd_data_row), .cmd_data_col(cmd_data_col),
        .cmd_key(cmd_key), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tag_reg(tag_reg), .arr_input_mode(arr_input_mode), .arr_wr_inhibit(arr_wr_inhibit),
        .arr_addr_in_row(arr_addr_in_row), .arr_addr_in_col(arr_addr_in_col),
        .arr_addr_out_row(arr_addr_out_row), .arr_addr_out_col(arr_addr_out_col),
        .arr_ip_row(arr_ip_row), .arr_ip_col(arr_ip_col), .arr_key(arr_key), .arr_mask(arr_mask),
        .arr_q_out_row(arr_q_out_row), .arr_q_out_col(arr_q_out_col), .arr_tag_row(arr_tag_row)
    );

    // Behavioural CAM array. Row mode writes a row and column mode writes a
    // column. COPY_B leaves the contents unchanged in this model.
    logic [DW-1:0] arr_mem [DD] = '{default: '0};

    always @(posedge clk) begin
        if (!arr_wr_inhibit) begin
            if (arr_input_mode == 3'd1 && int'(arr_addr_in_row) < DD)
                arr_mem[arr_addr_in_row[3:0]] <= arr_ip_row;
            else if (arr_input_mode == 3'd2 && int'(arr_addr_in_col) < DW)
                for (int r = 0; r < DD; r++)
                    arr_mem[r][arr_addr_in_col[2:0]] <= arr_ip_col[r];
        end
    end

    always_comb begin
        arr_q_out_row = '0;
        arr_q_out_col = '0;
        arr_tag_row   = '0;
        if (int'(arr_addr_out_row) < DD) arr_q_out_row = arr_mem[arr_addr_out_row[3:0]];
        for (int r = 0; r < DD; r++) begin
            if (int'(arr_addr_out_col) < DW) arr_q_out_col[r] = arr_mem[r][arr_addr_out_col[2:0]];
            arr_tag_row[r] = (((arr_mem[r] ^ {DW{arr_key}}) & arr_mask) == '0);
        end
    end

    // Command-level reference state
    logic [DW-1:0] ref_mem [DD];
    logic [DD-1:0] ref_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic mem_ok();
        for (int r = 0; r < DD; r++)
            if (arr_mem[r] !== ref_mem[r]) return 1'b0;
        return 1'b1;
    endfunction

    // Issue one command, predict its outcome and check the response.
    // If hold > 0, rsp_ready is kept low for hold cycles after rsp_valid rises.
    task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] drow, input logic [DD-1:0] dcol,
                          input logic key, input logic [DW-1:0] mask, input int hold);
        logic [DD-1:0] exp_data = '0;
        logic          exp_err  = 1'b0;
        int            exp_lat  = 2;
        int            exp_wr   = 0;
        int            a        = int'(addr);
        bit            row_op   = (op == 3'd0) || (op == 3'd2);
        bit            col_op   = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
        int            n, lat, wr;
        bit            seen;

        if (op == 3'd7 || (row_op && a >= DD) || (col_op && a >= DW)) begin
            exp_err = 1'b1;
        end else begin
            case (op)
                3'd0: begin ref_mem[a] = drow; exp_wr = 1; end
                3'd1: begin
                    for (int r = 0; r < DD; r++) ref_mem[r][a] = dcol[r];
                    exp_wr = 1;
                end
                3'd2: exp_data = {{(DD-DW){1'b0}}, ref_mem[a]};
                3'd3: for (int r = 0; r < DD; r++) exp_data[r] = ref_mem[r][a];
                3'd4: begin
                    for (int r = 0; r < DD; r++)
                        exp_data[r] = (((ref_mem[r] ^ {DW{key}}) & mask) == '0);
                    ref_tag = exp_data;
                end
                3'd5: begin
                    for (int r = 0; r < DD; r++)
                        if (ref_tag[r]) ref_mem[r][a] = dcol[r];
                    exp_wr  = 1;
                    exp_lat = 3;
                end
                default: exp_wr = 1;   // COPY_B
            endcase
        end

        @(negedge clk);
        cmd_op = op; cmd_addr = addr; cmd_data_row = drow; cmd_data_col = dcol;
        cmd_key = key; cmd_mask = mask; cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        lat = 0; wr = 0; seen = 0;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk);
            if (!arr_wr_inhibit) wr++;
            if (rsp_valid) begin seen = 1; lat = i; end
        end
        chk("rsp_latency", lat, exp_lat);
        chk("wr_low_cycles", wr, exp_wr);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
        chk("tag_reg", tag_reg, ref_tag);
        chk("cmd_ready_busy", cmd_ready, 0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, exp_data);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_inhibit", arr_wr_inhibit, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
        chk("array_contents", mem_ok(), 1);
    endtask

    initial begin
        logic [31:0] rnd;
        bit          seen;

        for (int r = 0; r < DD; r++) ref_mem[r] = '0;
        ref_tag = '0;
        rstIn = 1'b0; rsp_ready = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_addr = '0; cmd_data_row = '0; cmd_data_col = '0;
        cmd_key = 1'b0; cmd_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_tag_reg", tag_reg, 0);
        chk("rst_inhibit", arr_wr_inhibit, 1);
        chk("rst_mode", arr_input_mode, 0);
        chk("rst_ip_col", arr_ip_col, 0);
        rstIn = 1'b1;

        // Directed scenarios
        do_cmd(3'd0, 8'd3, 8'hA5, '0, 1'b0, '0, 0);
        do_cmd(3'd2, 8'd3, '0, '0, 1'b0, '0, 0);
        do_cmd(3'd1, 8'd2, '0, 16'hF00F, 1'b0, '0, 0);
        do_cmd(3'd3, 8'd2, '0, '0, 1'b0, '0, 0);
        for (int i = 0; i < DD; i++) do_cmd(3'd0, AW'(i), DW'(i), '0, 1'b0, '0, 0);
        do_cmd(3'd4, 8'd0, '0, '0, 1'b1, 8'h01, 0);
        chk("search_tags_aaaa", tag_reg, 16'hAAAA);
        do_cmd(3'd1, 8'd7, '0, 16'h0000, 1'b0, '0, 0);
        do_cmd(3'd5, 8'd7, '0, 16'hFFFF, 1'b0, '0, 0);
        do_cmd(3'd3, 8'd7, '0, '0, 1'b0, '0, 0);
        chk("tagwr_col7", rsp_data, 16'hAAAA);
        do_cmd(3'd2, 8'd0, '0, '0, 1'b0, '0, 0);
        do_cmd(3'd2, 8'd2, '0, '0, 1'b0, '0, 0);
        chk("row2_unchanged", rsp_data, 16'h0002);
        do_cmd(3'd0, 8'd16, 8'hFF, '0, 1'b0, '0, 0);
        do_cmd(3'd1, 8'd8, '0, 16'hFFFF, 1'b0, '0, 0);
        do_cmd(3'd7, 8'd0, 8'hFF, 16'hFFFF, 1'b0, '0, 5);
        do_cmd(3'd4, 8'd0, '0, '0, 1'b0, 8'h00, 0);
        chk("mask0_all_ones", rsp_data, 16'hFFFF);
        do_cmd(3'd6, 8'd0, '0, '0, 1'b0, '0, 0);
        do_cmd(3'd5, 8'd9, '0, 16'h1234, 1'b0, '0, 0);

        // Reset while a ROW_WR is in EXEC: the write and the response are both dropped.
        @(negedge clk);
        cmd_op = 3'd0; cmd_addr = 8'd1; cmd_data_row = 8'h3C; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rstIn = 1'b0;
        #1;
        chk("rst_exec_inhibit", arr_wr_inhibit, 1);
        chk("rst_exec_cmd_ready", cmd_ready, 1);
        chk("rst_exec_mode", arr_input_mode, 0);
        @(negedge clk);
        rstIn = 1'b1;
        ref_tag = '0;
        seen = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid) seen = 1; end
        chk("rst_no_response", seen, 0);
        chk("rst_row1_kept", arr_mem[1], ref_mem[1]);
        chk("rst_array", mem_ok(), 1);

        // Randomised commands
        for (int i = 0; i < 60; i++) begin
            logic [2:0]    op;
            logic [DW-1:0] m;
            rnd = $urandom;
            op  = rnd[2:0];
            m   = rnd[3] ? rnd[11:4] : DW'(1 << rnd[6:4]);
            do_cmd(op, AW'($urandom_range(0, 18)), rnd[19:12], $urandom, rnd[20], m,
                   (rnd[23:21] == 3'd0) ? 2 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_cmd_ctrl.md
# cam_cmd_ctrl

Command sequencer for the associative-processor CAM cell array. Accepts one command at a time over a valid/ready port and drives the array's mode, address, data, write-inhibit and search inputs for that command. Returns read data, search tags or an acknowledge over a valid/ready response port. Supports a two-cycle tag-conditional column write, implemented as a read-modify-write.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per CAM word (columns)
- DATA_DEPTH, 16, words in array (rows); must be >= DATA_WIDTH
- ADDR_WIDTH_CAM, 8, row/column address width
- RowxRow 3'd1, ColxCol 3'd2, COPY_B 3'd3, mode codes driven to the array

Ports:
- clk  in  1  single clock, rising edge
- rstIn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1; cmd_ready  out  1  command handshake
- cmd_op  in  3  0 ROW_WR, 1 COL_WR, 2 ROW_RD, 3 COL_RD, 4 SEARCH, 5 TAG_COL_WR, 6 COPY_B, 7 illegal
- cmd_addr  in  ADDR_WIDTH_CAM  row address (row ops) or column address (column ops)
- cmd_data_row  in  DATA_WIDTH; cmd_data_col  in  DATA_DEPTH  write data
- cmd_key  in  1; cmd_mask  in  DATA_WIDTH  search key bit and column mask
- rsp_valid  out  1; rsp_ready  in  1  response handshake
- rsp_data  out  DATA_DEPTH  read data (row read zero-extended in LSBs), tags, or 0
- rsp_err  out  1  illegal op or address out of range
- tag_reg  out  DATA_DEPTH  tags from the last successful SEARCH
- arr_input_mode  out  3; arr_wr_inhibit  out  1  (1 = array holds contents)
- arr_addr_in_row, arr_addr_in_col, arr_addr_out_row, arr_addr_out_col  out  ADDR_WIDTH_CAM
- arr_ip_row  out  DATA_WIDTH; arr_ip_col  out  DATA_DEPTH; arr_key  out  1; arr_mask  out  DATA_WIDTH
- arr_q_out_row  in  DATA_WIDTH; arr_q_out_col  in  DATA_DEPTH; arr_tag_row  in  DATA_DEPTH  array outputs, combinational from stored contents

## Operation
- States: IDLE, EXEC, RMW_WR, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields and go to EXEC. cmd_ready is 0 in every other state.
- Range check in EXEC: row ops need addr < DATA_DEPTH; column ops need addr < DATA_WIDTH. Op 7 or a failed check sets rsp_err=1 and rsp_data=0, performs no write, and goes to RESP.
- EXEC drives the array from the latched fields:
  - ROW_WR / COL_WR: mode RowxRow / ColxCol, matching input address, ip data, wr_inhibit=0. Goes to RESP with rsp_data=0.
  - ROW_RD / COL_RD: mode set, output address driven, wr_inhibit=1. Samples arr_q_out_* into rsp_data.
  - SEARCH: arr_key/arr_mask driven, wr_inhibit=1. Samples arr_tag_row into rsp_data and tag_reg.
  - COPY_B: mode COPY_B, wr_inhibit=0.
  - TAG_COL_WR: ColxCol, output column = addr, wr_inhibit=1. Captures old = arr_q_out_col, then goes to RMW_WR.
- RMW_WR: ColxCol, input column = addr, arr_ip_col = (tag_reg & data) | (~tag_reg & old), wr_inhibit=0, then RESP. Rows with tag 0 are rewritten unchanged.
- RESP: rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready, then IDLE.
- Outside write cycles: wr_inhibit=1, mode 3'd0, key 0, mask 0, data 0.

## Timing
- Reset (asynchronous, immediate): state IDLE; cmd_ready=1; rsp_valid=0, rsp_data=0, rsp_err=0, tag_reg=0; wr_inhibit=1; all other arr_* outputs 0. A command in flight is dropped with no write and no response.
- Handshake at edge of cycle k:
  - EXEC runs in k+1; the array write commits on the edge ending k+1.
  - rsp_valid rises in k+2 (k+3 for TAG_COL_WR).
- Minimum command spacing is 3 cycles (4 for TAG_COL_WR). No command is accepted while RESP is waiting.
- wr_inhibit is low for exactly one cycle per write command and never for reads, searches or errors.
- rsp_ready held high: response lasts one cycle. rsp_ready low: response holds indefinitely; the array is not touched.
- Read immediately after a write to the same location returns the new data, since the array updates at the commit edge.
- Search with cmd_mask=0 returns all-ones tags.

## Test plan
- Reset then ROW_WR addr 3 data 8'hA5, ROW_RD addr 3 -> rsp_data=16'h00A5, rsp_err=0; wr_inhibit low exactly one cycle.
- COL_WR col 2 data 16'hF00F, COL_RD col 2 -> 16'hF00F; rsp_valid 2 cycles after accept.
- Rows 0..15 written with value i; SEARCH key 1 mask 8'h01 -> rsp_data=tag_reg=16'hAAAA.
- After that search, column 7 = 0; TAG_COL_WR col 7 data 16'hFFFF; COL_RD col 7 -> 16'hAAAA; rows 0 and 2 unchanged.
- ROW_WR addr 16 and op 7 -> rsp_err=1, rsp_data=0, no write; rsp_ready held low 5 cycles -> response stable, cmd_ready=0.
- Assert rstIn low during EXEC of ROW_WR addr 1 data 8'h3C -> immediate IDLE, wr_inhibit=1, row 1 unchanged, no response.
